// File: rtl/tick_period_meter_if.sv
// Game-tick interface between the tick source (master) and the period meter (slave).
// The master drives the tick pulse; the meter drives all measurement results.
interface tick_period_meter_if #(
    parameter int CNT_W = 29
);
    logic             tick_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [3:0]       level;
    logic             faster;
    logic             restarted;
    logic             stalled;
    logic [15:0]      tick_count;

    modport master (
        output tick_pulse,
        input  period, period_valid, level, faster, restarted, stalled, tick_count
    );

    modport slave (
        input  tick_pulse,
        output period, period_valid, level, faster, restarted, stalled, tick_count
    );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the CLOCK_50 cycle count between game ticks, derives a speed level,
// flags speed-ups/restarts and detects a stalled tick source.
module tick_period_meter #(
    parameter int CNT_W        = 29,
    parameter int TIMEOUT      = 1048576,
    parameter int START_PERIOD = 572448,
    parameter int LEVEL_SHIFT  = 15
) (
    input logic                  CLOCK_50,
    input logic                  reset,
    tick_period_meter_if.slave   bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] START_C   = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LVL_MAX_C = CNT_W'(15);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, STALL} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] prev, prev_next;
    logic [CNT_W-1:0] period_q, period_next;
    logic [3:0]       level_q, level_next;
    logic             valid_q, valid_next;
    logic             faster_q, faster_next;
    logic             restarted_q, restarted_next;
    logic             stalled_q, stalled_next;
    logic [15:0]      count_q, count_next;
    logic [CNT_W-1:0] diff, shifted;
    logic [3:0]       level_calc;
    logic             tick;

    assign tick = bus.tick_pulse;

    // Level of the interval currently held in cnt, used only when a tick closes it.
    always_comb begin
        diff    = START_C - cnt;
        shifted = diff >> LEVEL_SHIFT;
        if (cnt >= START_C)
            level_calc = 4'd0;
        else if (shifted > LVL_MAX_C)
            level_calc = 4'd15;
        else
            level_calc = shifted[3:0];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (tick) state_next = ARMED;
            ARMED, RUN: begin
                if (tick)
                    state_next = RUN;
                else if (cnt == TIMEOUT_C)
                    state_next = STALL;
            end
            STALL:      if (tick) state_next = ARMED;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next       = cnt;
        prev_next      = prev;
        period_next    = period_q;
        level_next     = level_q;
        valid_next     = 1'b0;
        faster_next    = 1'b0;
        restarted_next = 1'b0;
        count_next     = tick ? count_q + 16'd1 : count_q;
        stalled_next   = (state_next == STALL);
        case (state)
            IDLE, STALL: begin
                // A stalled interval is discarded: re-arm without producing a strobe.
                if (tick) cnt_next = ONE_C;
            end
            ARMED, RUN: begin
                if (tick) begin
                    period_next = cnt;
                    level_next  = level_calc;
                    valid_next  = 1'b1;
                    if (state == RUN) begin
                        faster_next    = (cnt < prev);
                        restarted_next = (cnt > prev);
                    end
                    prev_next = cnt;
                    cnt_next  = ONE_C;
                end else if (cnt != TIMEOUT_C) begin
                    cnt_next = cnt + ONE_C;
                end
            end
            default: cnt_next = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            prev        <= '0;
            period_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            faster_q    <= 1'b0;
            restarted_q <= 1'b0;
            stalled_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            cnt         <= cnt_next;
            prev        <= prev_next;
            period_q    <= period_next;
            level_q     <= level_next;
            valid_q     <= valid_next;
            faster_q    <= faster_next;
            restarted_q <= restarted_next;
            stalled_q   <= stalled_next;
            count_q     <= count_next;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.level        = level_q;
    assign bus.faster       = faster_q;
    assign bus.restarted    = restarted_q;
    assign bus.stalled      = stalled_q;
    assign bus.tick_count   = count_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: timestamp-based reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized tick gaps and resets.
module tb_tick_period_meter;
    localparam int CNT_W = 29;
    localparam int TO    = 1000;
    localparam int SP    = 600;
    localparam int LS    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tick_period_meter_if #(.CNT_W(CNT_W)) bus();

    tick_period_meter #(
        .CNT_W(CNT_W),
        .TIMEOUT(TO),
        .START_PERIOD(SP),
        .LEVEL_SHIFT(LS)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: timestamps of ticks rather than counters.
    bit     seen, has_prev, check_en;
    longint last_t, prev_p, now;
    longint e_period;
    int     e_level, e_count;
    bit     e_valid, e_faster, e_restarted, e_stalled;

    function automatic int lvl(input longint p);
        longint q;
        if (p >= SP) return 0;
        q = (SP - p) >> LS;
        return (q > 15) ? 15 : int'(q);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        seen = 0; has_prev = 0; last_t = 0; prev_p = 0;
        e_period = 0; e_level = 0; e_count = 0;
        e_valid = 0; e_faster = 0; e_restarted = 0; e_stalled = 0;
    endtask

    task automatic step(input bit t);
        longint p;
        @(negedge clk);
        bus.tick_pulse = t;
        e_valid = 0; e_faster = 0; e_restarted = 0;
        if (t) begin
            e_count = (e_count + 1) % 65536;
            if (!seen) begin
                seen = 1; last_t = now;
            end else if (now - last_t > TO) begin
                last_t = now; has_prev = 0;
            end else begin
                p = now - last_t;
                e_valid  = 1;
                e_period = p;
                e_level  = lvl(p);
                if (has_prev) begin
                    e_faster    = (p < prev_p);
                    e_restarted = (p > prev_p);
                end
                prev_p = p; has_prev = 1; last_t = now;
            end
        end
        e_stalled = seen && (now - last_t >= TO);
        @(posedge clk);
        now++;
        #2;
    endtask

    task automatic reset_step(input bit t);
        @(negedge clk);
        rst = 1'b1;
        bus.tick_pulse = t;
        model_reset();
        check_en = 1;
        #1;
        chk("rst_period", bus.period, 0);
        chk("rst_valid", bus.period_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_faster", bus.faster, 0);
        chk("rst_restarted", bus.restarted, 0);
        chk("rst_stalled", bus.stalled, 0);
        chk("rst_count", bus.tick_count, 0);
        @(posedge clk);
        now++;
        #2;
        rst = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n - 1) step(0);
        step(1);
    endtask

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("period", bus.period, e_period);
            chk("period_valid", bus.period_valid, e_valid);
            chk("level", bus.level, e_level);
            chk("faster", bus.faster, e_faster);
            chk("restarted", bus.restarted, e_restarted);
            chk("stalled", bus.stalled, e_stalled);
            chk("tick_count", bus.tick_count, e_count);
        end
    end

    initial begin
        int r;
        int g;
        bus.tick_pulse = 1'b0;
        now = 0;
        model_reset();
        reset_step(0);

        repeat (10) step(0);
        step(1);
        chk("first_tick_no_strobe", bus.period_valid, 0);
        gap(500);
        chk("d1_period", bus.period, 500);
        chk("d1_level", bus.level, 3);
        chk("d1_faster", bus.faster, 0);
        chk("d1_restarted", bus.restarted, 0);
        chk("d1_valid", bus.period_valid, 1);
        chk("d1_count", bus.tick_count, 2);

        gap(480);
        chk("d2_period", bus.period, 480);
        chk("d2_faster", bus.faster, 1);
        chk("d2_level", bus.level, 3);
        gap(600);
        chk("d2b_period", bus.period, 600);
        chk("d2b_restarted", bus.restarted, 1);
        chk("d2b_level", bus.level, 0);

        gap(480);
        chk("d3_faster", bus.faster, 1);
        gap(480);
        chk("d3b_faster", bus.faster, 0);
        chk("d3b_restarted", bus.restarted, 0);
        chk("d3b_valid", bus.period_valid, 1);

        gap(TO);
        chk("timeout_edge_period", bus.period, TO);
        chk("timeout_edge_stalled", bus.stalled, 0);
        chk("timeout_edge_valid", bus.period_valid, 1);

        repeat (TO - 1) step(0);
        chk("pre_stall", bus.stalled, 0);
        step(0);
        chk("stall", bus.stalled, 1);
        step(1);
        chk("unstall", bus.stalled, 0);
        chk("unstall_no_strobe", bus.period_valid, 0);
        gap(50);
        chk("d4_period", bus.period, 50);
        chk("d4_level", bus.level, 15);
        chk("d4_faster", bus.faster, 0);
        chk("d4_restarted", bus.restarted, 0);

        step(1);
        chk("b2b_period", bus.period, 1);
        chk("b2b_valid", bus.period_valid, 1);
        step(1);
        chk("b2b2_period", bus.period, 1);
        chk("b2b2_valid", bus.period_valid, 1);
        step(0);
        chk("b2b_strobe_end", bus.period_valid, 0);

        repeat (100) step(0);
        reset_step(1);
        step(0);
        step(1);
        chk("post_rst_no_strobe", bus.period_valid, 0);
        chk("post_rst_count", bus.tick_count, 1);

        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      g = $urandom_range(1, 4);
            else if (r < 70) g = $urandom_range(400, 800);
            else if (r < 85) g = $urandom_range(TO - 5, TO + 5);
            else if (r < 95) g = $urandom_range(1, 200);
            else             g = 1500;
            gap(g);
            if ($urandom_range(0, 49) == 0) reset_step(1'($urandom_range(0, 1)));
        end

        step(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
